// File: rtl/crypto_key_reader_if.sv
// Key reader bus: key store read port plus the key word stream to the cipher core.
// master = key reader side, slave = key store / cipher core side.
`timescale 1ns/1ps
interface crypto_key_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              ks_rd_en;
  logic [ADDR_W-1:0] ks_addr;
  logic [DATA_W-1:0] ks_rd_data;
  logic [DATA_W-1:0] key_data;
  logic              key_valid;
  logic              key_ready;
  logic              key_last;

  modport master (
    output ks_rd_en, ks_addr, key_data, key_valid, key_last,
    input  ks_rd_data, key_ready
  );

  modport slave (
    input  ks_rd_en, ks_addr, key_data, key_valid, key_last,
    output ks_rd_data, key_ready
  );
endinterface

// File: rtl/crypto_key_reader.sv
// crypto_key_reader: on req, fetches NUM_WORDS key words from the key store
// (1-cycle read latency) and streams them, word 0 first, to the cipher core.
// key_data is zero whenever key_valid is low so no key material lingers.
// Optional feature: define KEY_READER_READ_ONCE_EN for a sticky read-once lock;
// once any word has been accepted, further req are rejected with err until reset.
//
// state   | meaning
// IDLE    | waiting for req
// FETCH   | ks_rd_en high for one cycle at ks_addr
// WAIT    | store data arrives, captured into key_data
// SEND    | key_valid high, waiting for key_ready
`timescale 1ns/1ps
module crypto_key_reader #(
  parameter int DATA_W    = 16,
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic err,
  crypto_key_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              ks_rd_en;
  logic [ADDR_W-1:0] ks_addr;
  logic [DATA_W-1:0] key_data;
  logic              key_valid;
  logic              key_last;
  logic              locked;

  assign bus.ks_rd_en  = ks_rd_en;
  assign bus.ks_addr   = ks_addr;
  assign bus.key_data  = key_data;
  assign bus.key_valid = key_valid;
  assign bus.key_last  = key_last;

`ifdef KEY_READER_READ_ONCE_EN
  logic lock;
  logic accept;

  // A word counts as accepted only if abort did not win the same edge.
  assign accept = (state == ST_SEND) && bus.key_ready && !abort;

  // Sticky lock: set by the first accepted word, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn)
      lock <= 1'b0;
    else if (accept)
      lock <= 1'b1;
  end

  assign locked = lock;
`else
  assign locked = 1'b0;
`endif

  // Sequencer: state, word index, store read strobe and key stream outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      ks_rd_en  <= 1'b0;
      ks_addr   <= '0;
      key_data  <= '0;
      key_valid <= 1'b0;
      key_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        // Abort outranks both req and a same-cycle handshake.
        state     <= ST_IDLE;
        idx       <= '0;
        ks_rd_en  <= 1'b0;
        ks_addr   <= '0;
        key_data  <= '0;
        key_valid <= 1'b0;
        key_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req) begin
              if (locked) begin
                err <= 1'b1;
              end else begin
                state    <= ST_FETCH;
                busy     <= 1'b1;
                ks_rd_en <= 1'b1;
                ks_addr  <= '0;
                idx      <= '0;
              end
            end
          end
          ST_FETCH: begin
            ks_rd_en <= 1'b0;
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            key_data  <= bus.ks_rd_data;
            key_valid <= 1'b1;
            key_last  <= (idx == LAST_IDX);
            state     <= ST_SEND;
          end
          ST_SEND: begin
            if (bus.key_ready) begin
              key_valid <= 1'b0;
              key_data  <= '0;
              key_last  <= 1'b0;
              if (idx == LAST_IDX) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                idx     <= '0;
                ks_addr <= '0;
                state   <= ST_IDLE;
              end else begin
                idx      <= idx + 1'b1;
                ks_addr  <= idx + 1'b1;
                ks_rd_en <= 1'b1;
                state    <= ST_FETCH;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crypto_key_reader.sv
// Directed bench for crypto_key_reader: reset, full read, backpressure,
// req while busy, abort, restart, reset mid-read and (optionally) read-once lock.
`timescale 1ns/1ps
module tb_crypto_key_reader;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic resetn;
  logic req;
  logic abort;
  logic busy;
  logic done;
  logic err;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;

  logic [15:0] mem [NW];

  crypto_key_reader_if #(.DATA_W(16), .ADDR_W(3)) kif ();

  crypto_key_reader #(.DATA_W(16), .NUM_WORDS(NW), .ADDR_W(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bus    (kif.master)
  );

  always #5 clk = ~clk;

  // Key store model: registered read, 16'hFFFF on the data port when not reading.
  initial kif.ks_rd_data = 16'hFFFF;
  always @(posedge clk)
    kif.ks_rd_data <= kif.ks_rd_en ? mem[kif.ks_addr] : 16'hFFFF;

  always @(negedge clk)
    if (done === 1'b1) done_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {kif.ks_rd_en, kif.ks_addr, kif.key_data, kif.key_valid, kif.key_last, busy, done, err}, 32'h0);
  endtask

  task automatic pre_read();
`ifdef KEY_READER_READ_ONCE_EN
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
`endif
  endtask

  // One key read; stall_w holds key_ready low 5 cycles, req_w pulses req,
  // abort_w aborts in SEND of that word (use -1 to disable each).
  task automatic run_read(input int stall_w, input int req_w, input int abort_w);
    int d0;
    d0 = done_cnt;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk("fetch_rd_en", kif.ks_rd_en, 1);
      chk("fetch_addr", kif.ks_addr, i);
      chk("fetch_busy_data_err", {busy, kif.key_valid, kif.key_data, err}, {1'b1, 18'h0});
      tick();
      chk("wait_rd_en_valid_data", {kif.ks_rd_en, kif.key_valid, kif.key_data}, 0);
      tick();
      chk("send_valid", kif.key_valid, 1);
      chk("send_data", kif.key_data, 16'h1000 + i);
      chk("send_last", kif.key_last, (i == NW - 1));
      if (i == req_w) req = 1'b1;
      if (i == stall_w) begin
        kif.key_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("stall_hold", {kif.key_valid, kif.key_data, kif.ks_rd_en}, {1'b1, 16'h1000 + i[15:0], 1'b0});
        end
        kif.key_ready = 1'b1;
      end
      if (i == abort_w) begin
        abort = 1'b1;
        req   = 1'b1;
        tick();
        abort = 1'b0;
        req   = 1'b0;
        chk_idle("abort_state");
        abort = 1'b1;
        req   = 1'b1;
        tick();
        abort = 1'b0;
        req   = 1'b0;
        chk_idle("abort_over_req_idle");
        tick();
        chk("abort_no_done", done_cnt, d0);
        return;
      end
      tick();
      req = 1'b0;
    end
    chk("end_done", done, 1);
    chk("end_busy_valid_data_last_err", {busy, kif.key_valid, kif.key_data, kif.key_last, err}, 0);
    tick();
    chk("done_pulse_width", done, 0);
    chk("done_count", done_cnt, d0 + 1);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 16'h1000 + 16'(i);
    resetn = 1'b0;
    req = 1'b0;
    abort = 1'b0;
    kif.key_ready = 1'b0;
    repeat (3) tick();
    chk_idle("reset");
    resetn = 1'b1;
    tick();
    chk_idle("post_reset");

    kif.key_ready = 1'b1;
    run_read(-1, -1, -1);

`ifdef KEY_READER_READ_ONCE_EN
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("lock_err", err, 1);
    chk("lock_rd_en_busy", {kif.ks_rd_en, busy}, 0);
    tick();
    chk("lock_err_pulse", err, 0);
    chk("lock_stays_idle", {kif.ks_rd_en, busy}, 0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
`endif

    run_read(2, 4, -1);
    pre_read();
    run_read(-1, -1, 3);
    pre_read();
    run_read(-1, -1, -1);

    pre_read();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    chk_idle("reset_mid_read");
    resetn = 1'b1;
    tick();
    chk_idle("after_mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
